// File: rtl/mlp_pkg.sv
// mlp_pkg: state encoding, default widths and saturation helper shared by the MLP layer engine
package mlp_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WRITE, DONE} state_t;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_FRAC_W = 8;
  // Clamp v to the signed range of a w-bit value
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/mlp_mac.sv
// mlp_mac: registered signed multiply-accumulate with bias injection
//   clk, reset (async active-low), clr (zero acc, highest priority),
//   en (acc += a*b), bias_en (acc += b << FRAC_W), a/b operands, acc result
module mlp_mac #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = 40
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     en,
  input  logic                     bias_en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);
  logic signed [2*DATA_W-1:0] prod;
  assign prod = (2*DATA_W)'(a) * (2*DATA_W)'(b);
  always_ff @(posedge clk or negedge reset)
    if (!reset) acc <= '0;
    else if (clr) acc <= '0;
    else if (en) acc <= acc + ACC_W'(prod);
    else if (bias_en) acc <= acc + (ACC_W'(b) <<< FRAC_W);
endmodule

// File: rtl/mlp_layer_engine.sv
// mlp_layer_engine: fully-connected layer sequencer over an external synchronous weight memory
//   clk, reset (async active-low), start, in_data (packed N_IN inputs)
//   w_rd/w_addr/w_data: weight memory port, data returns one cycle after w_rd
//   out_valid/out_idx/out_data: one pulse per neuron result; busy, finished (sticky)
//   Build option MLP_RELU_EN: clip negative results to zero
module mlp_layer_engine
  import mlp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int N_IN   = 4,
  parameter int N_OUT  = 4,
  parameter int ACC_W  = 40,
  localparam int AW = $clog2(N_OUT * (N_IN + 1)),
  localparam int IW = N_OUT > 1 ? $clog2(N_OUT) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [N_IN*DATA_W-1:0]   in_data,
  output logic                     w_rd,
  output logic [AW-1:0]            w_addr,
  input  logic [DATA_W-1:0]        w_data,
  output logic                     out_valid,
  output logic [IW-1:0]            out_idx,
  output logic [DATA_W-1:0]        out_data,
  output logic                     busy,
  output logic                     finished
);
  localparam int KW = $clog2(N_IN + 1);
  state_t state;
  logic [N_IN*DATA_W-1:0] in_reg;
  logic [KW-1:0] k, data_k;
  logic [IW-1:0] j;
  logic data_vld, go, clr, en, bias_en;
  logic signed [DATA_W-1:0] a, sat, res;
  logic signed [ACC_W-1:0] acc;
  // busy stays high through the first DONE cycle so completion lands one edge after the last result
  assign go = start && !busy;
  assign clr = go || state == WRITE;
  // data_vld/data_k follow the read strobe by one cycle, matching the memory latency
  assign en = data_vld && data_k != KW'(N_IN);
  assign bias_en = data_vld && data_k == KW'(N_IN);
  always_comb begin
    a = '0;
    for (int i = 0; i < N_IN; i++) a = data_k == KW'(i) ? in_reg[i*DATA_W +: DATA_W] : a;
    sat = DATA_W'(saturate(64'(acc >>> FRAC_W), DATA_W));
`ifdef MLP_RELU_EN
    res = sat < 0 ? '0 : sat;
`else
    res = sat;
`endif
  end
  mlp_mac #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W)) u_mac (
    .clk(clk), .reset(reset), .clr(clr), .en(en), .bias_en(bias_en),
    .a(a), .b(w_data), .acc(acc)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      in_reg <= '0;
      j <= '0;
      k <= '0;
      data_k <= '0;
      data_vld <= 1'b0;
      w_rd <= 1'b0;
      w_addr <= '0;
      out_valid <= 1'b0;
      out_idx <= '0;
      out_data <= '0;
      busy <= 1'b0;
      finished <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      data_vld <= w_rd;
      data_k <= k;
      case (state)
        IDLE, DONE:
          if (go) begin
            in_reg <= in_data;
            j <= '0;
            k <= '0;
            w_rd <= 1'b1;
            w_addr <= '0;
            busy <= 1'b1;
            finished <= 1'b0;
            state <= FETCH;
          end else if (state == DONE) begin
            busy <= 1'b0;
            finished <= 1'b1;
          end
        FETCH:
          if (k == KW'(N_IN)) begin
            w_rd <= 1'b0;
            state <= DRAIN;
          end else begin
            k <= k + KW'(1);
            w_addr <= w_addr + AW'(1);
          end
        DRAIN: state <= WRITE;
        WRITE: begin
          out_valid <= 1'b1;
          out_idx <= j;
          out_data <= res;
          if (j == IW'(N_OUT - 1)) state <= DONE;
          else begin
            j <= j + IW'(1);
            k <= '0;
            w_rd <= 1'b1;
            w_addr <= w_addr + AW'(1);
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mlp_layer_engine.sv
// tb_mlp_layer_engine: directed and randomized checks of mlp_layer_engine against an arithmetic reference model
module tb_mlp_layer_engine;
  logic clk = 1'b0, rst_n, start, w_rd, out_valid, busy, finished;
  logic [63:0] in_data;
  logic [4:0] w_addr;
  logic [15:0] w_data, out_data;
  logic [1:0] out_idx;
  logic signed [15:0] mem [20];
  logic signed [15:0] vin [4];
  int checks, errors, fin_cyc, ev;
  logic f0, b0, b28, b29;
  int vcyc[$], acyc[$], aadr[$];
  logic [1:0] vidx[$];
  logic [15:0] vdat[$];
  logic [15:0] id_res [4];

  mlp_layer_engine dut (
    .clk(clk), .reset(rst_n), .start(start), .in_data(in_data),
    .w_rd(w_rd), .w_addr(w_addr), .w_data(w_data),
    .out_valid(out_valid), .out_idx(out_idx), .out_data(out_data),
    .busy(busy), .finished(finished)
  );

  always #5 clk = ~clk;

  // Synchronous weight memory; garbage on the bus whenever no read was issued
  always @(posedge clk) w_data <= w_rd ? mem[w_addr] : 16'($urandom);

  function automatic logic [63:0] pack();
    return {vin[3], vin[2], vin[1], vin[0]};
  endfunction

  // Reference neuron: exact integer dot product, rescale, clamp, optional clip
  function automatic logic [15:0] model(input int j);
    longint s = 0;
    for (int k = 0; k < 4; k++) s += longint'(vin[k]) * longint'(mem[j*5+k]);
    s += longint'(mem[j*5+4]) * 256;
    s = s >>> 8;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`ifdef MLP_RELU_EN
    if (s < 0) s = 0;
`endif
    return 16'(s);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_mem(input logic [15:0] wv, input logic [15:0] bv, input bit ident);
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < 5; k++)
        mem[j*5+k] = k == 4 ? bv : ident ? (j == k ? 16'h0100 : 16'h0000) : wv;
  endtask

  // One layer run; samples every cycle from E0 (n=0) to E0+31, 1 time unit after each edge
  task automatic run(input int pulse_at, input bit scramble);
    vcyc.delete(); vidx.delete(); vdat.delete(); acyc.delete(); aadr.delete();
    fin_cyc = -1;
    @(negedge clk);
    in_data = pack();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 0; n <= 31; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      if (out_valid) begin
        vcyc.push_back(n);
        vidx.push_back(out_idx);
        vdat.push_back(out_data);
      end
      if (w_rd) begin
        acyc.push_back(n);
        aadr.push_back(int'(w_addr));
      end
      if (finished && fin_cyc < 0) fin_cyc = n;
      if (n == 0) begin
        f0 = finished;
        b0 = busy;
      end
      if (n == 28) b28 = busy;
      if (n == 29) b29 = busy;
      if (scramble && n > 0 && n < 28) in_data = {$urandom, $urandom};
      start = n == pulse_at - 1;
    end
    start = 1'b0;
    in_data = pack();
  endtask

  task automatic verify(input string tag);
    check({tag, " n_valid"}, vcyc.size(), 4);
    for (int j = 0; j < vcyc.size() && j < 4; j++) begin
      check($sformatf("%s valid_cyc%0d", tag, j), vcyc[j], 7 * (j + 1));
      check($sformatf("%s idx%0d", tag, j), vidx[j], j);
      check($sformatf("%s data%0d", tag, j), vdat[j], model(j));
    end
    check({tag, " finished_cyc"}, fin_cyc, 29);
    check({tag, " finished_clr_at_start"}, f0, 1'b0);
    check({tag, " busy_at_start"}, b0, 1'b1);
    check({tag, " busy_at_28"}, b28, 1'b1);
    check({tag, " busy_at_29"}, b29, 1'b0);
    check({tag, " n_reads"}, acyc.size(), 20);
    for (int i = 0; i < acyc.size() && i < 20; i++) begin
      check($sformatf("%s addr%0d", tag, i), aadr[i], i);
      check($sformatf("%s rd_cyc%0d", tag, i), acyc[i], 7 * (i / 5) + i % 5);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    start = 1'b0;
    in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset w_rd", w_rd, 1'b0);
    check("reset w_addr", w_addr, 5'd0);
    check("reset out_valid", out_valid, 1'b0);
    check("reset out_idx", out_idx, 2'd0);
    check("reset out_data", out_data, 16'd0);
    check("reset busy", busy, 1'b0);
    check("reset finished", finished, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    set_mem(16'h0, 16'h0, 1'b1);
    vin = '{16'h0100, 16'h0200, 16'hFD00, 16'h0080};
    run(-1, 1'b0);
    verify("ident");
    check("ident const0", vdat[0], 16'h0100);
    check("ident const1", vdat[1], 16'h0200);
`ifdef MLP_RELU_EN
    check("ident const2", vdat[2], 16'h0000);
`else
    check("ident const2", vdat[2], 16'hFD00);
`endif
    check("ident const3", vdat[3], 16'h0080);
    for (int j = 0; j < 4; j++) id_res[j] = model(j);

    @(negedge clk);
    in_data = pack();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst outputs", {w_rd, out_valid, busy, finished, out_idx, out_data, w_addr}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ev = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid || w_rd || busy || finished) ev++;
    end
    check("midrst quiet", ev, 0);
    run(-1, 1'b0);
    verify("after_rst");
    for (int j = 0; j < 4 && j < vdat.size(); j++) check($sformatf("after_rst same%0d", j), vdat[j], id_res[j]);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 20; i++) mem[i] = r[0] ? 16'($urandom_range(0, 1023)) - 16'sd512 : 16'($urandom);
      for (int i = 0; i < 4; i++) vin[i] = r[0] ? 16'($urandom_range(0, 2047)) - 16'sd1024 : 16'($urandom);
      run(-1, r[1]);
      verify($sformatf("rand%0d", r));
    end

    set_mem(16'h7FFF, 16'h0, 1'b0);
    vin = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    run(-1, 1'b0);
    verify("sat_pos");
    check("sat_pos const", vdat[0], 16'h7FFF);
    set_mem(16'h8000, 16'h0, 1'b0);
    run(-1, 1'b0);
    verify("sat_neg");
`ifdef MLP_RELU_EN
    check("sat_neg const", vdat[0], 16'h0000);
`else
    check("sat_neg const", vdat[0], 16'h8000);
`endif

    set_mem(16'h0, 16'h0180, 1'b0);
    run(-1, 1'b0);
    verify("bias_pos");
    check("bias_pos const", vdat[1], 16'h0180);
    set_mem(16'h0, 16'hFF00, 1'b0);
    run(-1, 1'b0);
    verify("bias_neg");
`ifdef MLP_RELU_EN
    check("bias_neg const", vdat[2], 16'h0000);
`else
    check("bias_neg const", vdat[2], 16'hFF00);
`endif

    set_mem(16'h0, 16'h0, 1'b1);
    vin = '{16'h0100, 16'h0200, 16'hFD00, 16'h0080};
    run(5, 1'b1);
    verify("start_busy");
    for (int j = 0; j < 4 && j < vdat.size(); j++) check($sformatf("start_busy same%0d", j), vdat[j], id_res[j]);
    check("done before restart", finished, 1'b1);
    run(-1, 1'b0);
    verify("back2back");
    for (int j = 0; j < 4 && j < vdat.size(); j++) check($sformatf("back2back same%0d", j), vdat[j], id_res[j]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
